// File: rtl/ooo_pkg.sv
// ooo_pkg: shared definitions for the in-order dispatch slice.
//     - disp_state_e : dispatch FSM state encoding (IDLE / WAIT / HOLD)
//     - FU_CODE_W    : default width of funcUnitType (value = target RS index)
//     - CREDIT_W     : default width of a per-RS credit counter
package ooo_pkg;

    localparam int FU_CODE_W = 3;
    localparam int CREDIT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } disp_state_e;

endpackage

// File: rtl/rs_credit_counter.sv
// rs_credit_counter: free-entry credit tracker for one reservation station.
// Starts at RS_DEPTH (RS empty). dec consumes a credit on dispatch, inc returns
// one when the RS frees an entry.
// Ports:
//     clock_i  in   clock
//     reset_i  in   async active-high reset, reloads RS_DEPTH
//     inc      in   credit return from the RS
//     dec      in   credit consumed by a dispatch
//     count    out  current credit count
//     nonzero  out  count != 0
module rs_credit_counter
    import ooo_pkg::*;
#(
    parameter int CREDIT_BITS = CREDIT_W,
    parameter int RS_DEPTH    = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   inc,
    input  logic                   dec,
    output logic [CREDIT_BITS-1:0] count,
    output logic                   nonzero
);

    localparam logic [CREDIT_BITS-1:0] MAX_CREDIT = CREDIT_BITS'(RS_DEPTH);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count <= MAX_CREDIT;
        end else if (inc && dec) begin
            count <= count;
        end else if (dec) begin
            count <= count - 1'b1;
        end else if (inc && (count != MAX_CREDIT)) begin
            // A return at full credit is spurious and is dropped.
            count <= count + 1'b1;
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/inorder_dispatch_ctrl.sv
// inorder_dispatch_ctrl: dequeues the in-order instruction queue and routes each
// entry to the reservation station selected by its funcUnitType, stalling while
// the target RS has no free credit.
// Optional build macro: DISPATCH_PERF_EN enables the dispatch/stall perf counters;
// without it dispatchCount_o and stallCount_o are tied to 0.
// Ports:
//     clock_i, reset_i        clock, async active-high reset
//     queueEmpty_i            queue is empty
//     readEnable_o            1-cycle dequeue strobe
//     funcUnitType_i, majID_i queue output, valid the cycle after readEnable_o
//     flush_i                 drops any in-flight entry
//     creditReturn_i          per-RS one-entry-freed strobes
//     dispatchValid_o/RsSel/MajID  registered dispatch write to an RS
//     stall_o                 held entry waiting on a full RS
//     illegalFu_o             sticky: out-of-range funcUnitType seen
//     dispatchCount_o, stallCount_o  perf counters
module inorder_dispatch_ctrl
    import ooo_pkg::*;
#(
    parameter int funcUnitCodeSize        = FU_CODE_W,
    parameter int NUM_RS                  = 4,
    parameter int RS_DEPTH                = 8,
    parameter int CREDIT_BITS             = CREDIT_W,
    parameter int instructionCounterWidth = 64
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               queueEmpty_i,
    output logic                               readEnable_o,
    input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] majID_i,
    input  logic                               flush_i,
    input  logic [NUM_RS-1:0]                  creditReturn_i,
    output logic                               dispatchValid_o,
    output logic [NUM_RS-1:0]                  dispatchRsSel_o,
    output logic [instructionCounterWidth-1:0] dispatchMajID_o,
    output logic                               stall_o,
    output logic                               illegalFu_o,
    output logic [31:0]                        dispatchCount_o,
    output logic [31:0]                        stallCount_o
);

    disp_state_e state_q, state_d;

    logic [funcUnitCodeSize-1:0]        hold_fu_p1;
    logic [instructionCounterWidth-1:0] hold_maj_p1;

    logic [NUM_RS-1:0]      tgt_onehot;
    logic                   tgt_legal;
    logic [NUM_RS-1:0]      rs_nonzero;
    logic [NUM_RS-1:0]      rs_empty;
    logic [NUM_RS-1:0]      rs_dec;
    logic [CREDIT_BITS-1:0] rs_count [NUM_RS];
    logic                   credit_ok;
    logic                   credit_zero;

    logic read_en, latch_en, disp_go, stall, illegal_hit;

    logic                               disp_vld_p2;
    logic [NUM_RS-1:0]                  disp_sel_p2;
    logic [instructionCounterWidth-1:0] disp_maj_p2;
    logic                               illegal_q;

    // Target decode of the held entry
    always_comb begin
        tgt_onehot = '0;
        for (int n = 0; n < NUM_RS; n++) begin
            tgt_onehot[n] = (int'(hold_fu_p1) == n);
        end
    end

    assign tgt_legal = (int'(hold_fu_p1) < NUM_RS);
    // A return arriving this cycle can be spent immediately, even at zero credit.
    assign credit_ok   = |(tgt_onehot & (rs_nonzero | creditReturn_i));
    assign credit_zero = |(tgt_onehot & rs_empty & ~creditReturn_i);

    genvar n;
    generate
        for (n = 0; n < NUM_RS; n++) begin : g_rs
            rs_credit_counter #(
                .CREDIT_BITS (CREDIT_BITS),
                .RS_DEPTH    (RS_DEPTH)
            ) u_credit (
                .clock_i (clock_i),
                .reset_i (reset_i),
                .inc     (creditReturn_i[n]),
                .dec     (rs_dec[n]),
                .count   (rs_count[n]),
                .nonzero (rs_nonzero[n])
            );
            assign rs_empty[n] = (rs_count[n] == '0);
        end
    endgenerate

    assign rs_dec = disp_go ? tgt_onehot : '0;

    always_comb begin
        state_d     = state_q;
        read_en     = 1'b0;
        latch_en    = 1'b0;
        disp_go     = 1'b0;
        stall       = 1'b0;
        illegal_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!queueEmpty_i && !flush_i) begin
                    read_en = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    latch_en = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (!tgt_legal) begin
                    illegal_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else if (credit_ok) begin
                    disp_go = 1'b1;
                    // Overlap the next dequeue with this dispatch.
                    if (!queueEmpty_i) begin
                        read_en = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    stall = credit_zero;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign readEnable_o = read_en;
    assign stall_o      = stall;

    // Stage p1: capture queue output while in WAIT
    always_ff @(posedge clock_i) begin
        if (latch_en) begin
            hold_fu_p1  <= funcUnitType_i;
            hold_maj_p1 <= majID_i;
        end
    end

    // Stage p2: registered dispatch write to the RS
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            disp_vld_p2 <= 1'b0;
            disp_sel_p2 <= '0;
            disp_maj_p2 <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_vld_p2 <= disp_go;
            disp_sel_p2 <= disp_go ? tgt_onehot : '0;
            if (disp_go) begin
                disp_maj_p2 <= hold_maj_p1;
            end
            illegal_q   <= illegal_q | illegal_hit;
        end
    end

    assign dispatchValid_o = disp_vld_p2;
    assign dispatchRsSel_o = disp_sel_p2;
    assign dispatchMajID_o = disp_maj_p2;
    assign illegalFu_o     = illegal_q;

`ifdef DISPATCH_PERF_EN
    logic [31:0] disp_cnt_q, stall_cnt_q;

    // Counting the dispatch decision keeps the counter in step with dispatchValid_o.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            disp_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (disp_go) disp_cnt_q  <= disp_cnt_q + 32'd1;
            if (stall)   stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign dispatchCount_o = disp_cnt_q;
    assign stallCount_o    = stall_cnt_q;
`else
    assign dispatchCount_o = '0;
    assign stallCount_o    = '0;
`endif

endmodule

// File: tb/tb_inorder_dispatch_ctrl.sv
// tb_inorder_dispatch_ctrl: directed scenarios followed by a random phase, all
// checked against a transaction-level model: a source queue, the ordered list of
// legal entries that must be dispatched, and per-RS occupancy (RS_DEPTH - credit).
module tb_inorder_dispatch_ctrl;

    localparam int NRS   = 4;
    localparam int DEPTH = 8;
`ifdef DISPATCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  fu;
        logic [63:0] maj;
    } ent_t;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        queueEmpty_i;
    logic        readEnable_o;
    logic [2:0]  funcUnitType_i;
    logic [63:0] majID_i;
    logic        flush_i;
    logic [3:0]  creditReturn_i;
    logic        dispatchValid_o;
    logic [3:0]  dispatchRsSel_o;
    logic [63:0] dispatchMajID_o;
    logic        stall_o;
    logic        illegalFu_o;
    logic [31:0] dispatchCount_o;
    logic [31:0] stallCount_o;

    always #5 clock_i = ~clock_i;

    inorder_dispatch_ctrl dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .queueEmpty_i    (queueEmpty_i),
        .readEnable_o    (readEnable_o),
        .funcUnitType_i  (funcUnitType_i),
        .majID_i         (majID_i),
        .flush_i         (flush_i),
        .creditReturn_i  (creditReturn_i),
        .dispatchValid_o (dispatchValid_o),
        .dispatchRsSel_o (dispatchRsSel_o),
        .dispatchMajID_o (dispatchMajID_o),
        .stall_o         (stall_o),
        .illegalFu_o     (illegalFu_o),
        .dispatchCount_o (dispatchCount_o),
        .stallCount_o    (stallCount_o)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t src_q [$];
    ent_t exp_q [$];
    int   occ [NRS];
    int   rsdisp [NRS];
    int   cyc = 0, re_cyc = -1, disp_cyc = -1;
    int   ndisp = 0, nstall = 0, n_re = 0;
    bit   rand_ret = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] fu, input logic [63:0] m, input bit will_dispatch);
        ent_t e;
        e.fu  = fu;
        e.maj = m;
        src_q.push_back(e);
        if (will_dispatch) exp_q.push_back(e);
        queueEmpty_i = 1'b0;
    endtask

    // One clock: called at edge+1, samples combinational outputs mid-cycle,
    // then models the queue pop, credit returns and dispatch stream after the edge.
    task automatic tick();
        bit   re, st;
        ent_t e;
        if (rand_ret) begin
            for (int n = 0; n < NRS; n++)
                creditReturn_i[n] = (occ[n] > 0) && ($urandom_range(0, 2) == 0);
        end
        #4;
        re = readEnable_o;
        st = stall_o;
        if (re) chk("read_nonempty", src_q.size() > 0, 1);
        if (st) begin
            chk("stall_has_head", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("stall_rs_full", occ[exp_q[0].fu], DEPTH);
        end
        @(posedge clock_i);
        #1;
        cyc++;
        if (st) nstall++;
        for (int n = 0; n < NRS; n++) if (creditReturn_i[n]) occ[n]--;
        if (re) begin
            n_re++;
            re_cyc = cyc;
            if (src_q.size() > 0) begin
                e = src_q.pop_front();
                funcUnitType_i = e.fu;
                majID_i        = e.maj;
            end
        end
        queueEmpty_i = (src_q.size() == 0);
        if (dispatchValid_o) begin
            disp_cyc = cyc;
            ndisp++;
            chk("dispatch_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rs_sel", {60'd0, dispatchRsSel_o}, 64'd1 << e.fu);
                chk("majid", dispatchMajID_o, e.maj);
                occ[e.fu]++;
                rsdisp[e.fu]++;
                chk("credit_bound", occ[e.fu] <= DEPTH, 1);
            end
        end
        chk("disp_count", {32'd0, dispatchCount_o}, PERF ? 64'(ndisp) : 64'd0);
        chk("stall_count", {32'd0, stallCount_o}, PERF ? 64'(nstall) : 64'd0);
        creditReturn_i = '0;
        flush_i        = 1'b0;
    endtask

    task automatic wait_disp(input int budget);
        int n0 = ndisp;
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ndisp != n0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dispatch_timeout", ok, 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && src_q.size() == 0 &&
                occ[0] == 0 && occ[1] == 0 && occ[2] == 0 && occ[3] == 0) begin
                done = 1'b1;
                break;
            end
            for (int n = 0; n < NRS; n++) creditReturn_i[n] = (occ[n] > 0);
            tick();
        end
        chk("drain_done", done, 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_vld"}, dispatchValid_o, 0);
        chk({tag, "_sel"}, {60'd0, dispatchRsSel_o}, 0);
        chk({tag, "_maj"}, dispatchMajID_o, 0);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_illegal"}, illegalFu_o, 0);
        chk({tag, "_dcnt"}, {32'd0, dispatchCount_o}, 0);
        chk({tag, "_scnt"}, {32'd0, stallCount_o}, 0);
    endtask

    initial begin
        int d0, r0;
        reset_i = 1'b0; queueEmpty_i = 1'b1; flush_i = 1'b0;
        creditReturn_i = '0; funcUnitType_i = '0; majID_i = '0;
        for (int n = 0; n < NRS; n++) begin occ[n] = 0; rsdisp[n] = 0; end

        // Reset and idle with an empty queue
        #1 reset_i = 1'b1;
        @(posedge clock_i);
        #1;
        chk_idle_outputs("rst");
        chk("rst_read", readEnable_o, 0);
        reset_i = 1'b0;
        r0 = n_re;
        repeat (10) tick();
        chk("idle_no_read", n_re - r0, 0);
        chk_idle_outputs("idle");

        // Single entry latency and routing
        push(3'd2, 64'h55, 1'b1);
        wait_disp(10);
        chk("t2_latency", disp_cyc - re_cyc, 2);
        chk("t2_sel", {60'd0, dispatchRsSel_o}, 64'b0100);
        chk("t2_maj", dispatchMajID_o, 64'h55);
        tick();
        chk("t2_strobe", dispatchValid_o, 0);
        drain();

        // Nine entries to RS1: eight dispatch, ninth stalls until a return
        d0 = rsdisp[1];
        for (int i = 0; i < 9; i++) push(3'd1, 64'h100 + 64'(i), 1'b1);
        repeat (25) tick();
        chk("t3_eight", rsdisp[1] - d0, 8);
        chk("t3_stall", stall_o, 1);
        creditReturn_i[1] = 1'b1;
        tick();
        chk("t3_ninth", dispatchValid_o, 1);
        chk("t3_nine", rsdisp[1] - d0, 9);
        drain();

        // Dispatch and return on RS0 in the same cycle at credit 1
        for (int i = 0; i < 7; i++) push(3'd0, 64'h200 + 64'(i), 1'b1);
        repeat (20) tick();
        chk("t4_occ7", occ[0], 7);
        push(3'd0, 64'h400, 1'b1);
        tick();
        tick();
        creditReturn_i[0] = 1'b1;
        tick();
        chk("t4_disp", dispatchValid_o, 1);
        chk("t4_occ_same", occ[0], 7);
        d0 = rsdisp[0];
        push(3'd0, 64'h401, 1'b1);
        push(3'd0, 64'h402, 1'b1);
        repeat (12) tick();
        chk("t4_one_more", rsdisp[0] - d0, 1);
        chk("t4_stall", stall_o, 1);
        drain();

        // Flush during WAIT
        d0 = ndisp;
        push(3'd3, 64'h333, 1'b0);
        tick();
        flush_i = 1'b1;
        tick();
        repeat (4) tick();
        chk("t5_no_disp", ndisp - d0, 0);
        chk("t5_occ3", occ[3], 0);
        push(3'd3, 64'h334, 1'b1);
        tick();
        chk("t5_idle_read", re_cyc, cyc);
        wait_disp(10);
        chk("t5_latency", disp_cyc - re_cyc, 2);
        drain();

        // Illegal functional unit code
        chk("t6_pre_illegal", illegalFu_o, 0);
        push(3'd7, 64'h77, 1'b0);
        push(3'd0, 64'h66, 1'b1);
        wait_disp(20);
        chk("t6_illegal", illegalFu_o, 1);
        chk("t6_next_maj", dispatchMajID_o, 64'h66);
        repeat (3) tick();
        chk("t6_sticky", illegalFu_o, 1);
        drain();

        // Random traffic with random credit returns
        rand_ret = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [2:0] f;
                f = 3'($urandom_range(0, 4));
                push(f, {$urandom, $urandom}, f < 3'd4);
            end
            tick();
        end
        rand_ret = 1'b0;
        drain();
        chk("rand_illegal_sticky", illegalFu_o, 1);

        // Reset while an entry is held
        push(3'd1, 64'hAA, 1'b0);
        tick();
        tick();
        reset_i = 1'b1;
        #1;
        ndisp = 0;
        nstall = 0;
        chk_idle_outputs("midrst");
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        d0 = ndisp;
        repeat (5) tick();
        chk("midrst_dropped", ndisp - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
